// File: rtl/i2c_bus_conditioner_if.sv
// Bus-side signal bundle of the I2C bus conditioner: raw pins in, filtered lines and
// bus-event pulses out. The conditioner connects through the slave modport.
interface i2c_bus_conditioner_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic sda_o;
  logic scl_rise;
  logic scl_fall;
  logic start_pulse;
  logic stop_pulse;
  logic bus_busy;
  logic timeout;

  modport master (
    output scl_i, sda_i,
    input  scl_o, sda_o, scl_rise, scl_fall, start_pulse, stop_pulse, bus_busy, timeout
  );

  modport slave (
    input  scl_i, sda_i,
    output scl_o, sda_o, scl_rise, scl_fall, start_pulse, stop_pulse, bus_busy, timeout
  );
endinterface

// File: rtl/i2c_bus_conditioner.sv
// I2C bus conditioner: synchronizes and glitch-filters SCL/SDA, detects START/STOP and
// tracks bus busy. Define I2C_COND_TIMEOUT_EN to add the stuck-SCL-low timeout.
module i2c_bus_conditioner #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rstn,
  i2c_bus_conditioner_if.slave  bus
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'hF_FFFF)
  begin : g_param_check
    $error("i2c_bus_conditioner: FILTER_LEN or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef struct packed {
    logic       val;
    logic [3:0] cnt;
  } filt_t;

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  // A line only changes once FILTER_LEN consecutive samples disagree with it.
  function automatic filt_t filter_step(input logic sample, input filt_t cur);
    filt_t nxt;
    nxt.val = cur.val;
    nxt.cnt = 4'd0;
    if (sample != cur.val) begin
      if (cur.cnt == CNT_LAST) nxt.val = sample;
      else                     nxt.cnt = cur.cnt + 4'd1;
    end
    return nxt;
  endfunction

  logic [1:0] scl_sync_q, sda_sync_q;
  filt_t      scl_q, scl_d, sda_q, sda_d;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q, busy_q, timeout_q;
  logic       start_d, stop_d, timeout_d;
  state_e     state_q;

  // NOTE: every next-state value gets an unconditional assignment in always_comb, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    scl_d   = filter_step(scl_sync_q[1], scl_q);
    sda_d   = filter_step(sda_sync_q[1], sda_q);
    // SCL must be high both before and after the SDA edge; a simultaneous SCL change
    // therefore suppresses START/STOP.
    start_d = sda_q.val & ~sda_d.val & scl_q.val & scl_d.val;
    stop_d  = ~sda_q.val & sda_d.val & scl_q.val & scl_d.val;
  end

`ifdef I2C_COND_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d  = 20'd0;
    timeout_d = 1'b0;
    if (state_q == BUSY && !scl_q.val) begin
      if (to_cnt_q == TO_LAST) timeout_d = 1'b1;
      else                     to_cnt_d  = to_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) to_cnt_q <= 20'd0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_d = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_q      <= '{val: 1'b1, cnt: 4'd0};
      sda_q      <= '{val: 1'b1, cnt: 4'd0};
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      state_q    <= IDLE;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[0], bus.sda_i};
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      scl_rise_q <= scl_d.val & ~scl_q.val;
      scl_fall_q <= ~scl_d.val & scl_q.val;
      start_q    <= start_d;
      stop_q     <= stop_d;
      timeout_q  <= timeout_d;
      case (state_q)
        IDLE: if (start_d) begin
          state_q <= BUSY;
          busy_q  <= 1'b1;
        end
        BUSY: if (!start_d && (stop_d || timeout_d)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scl_o       = scl_q.val;
  assign bus.sda_o       = sda_q.val;
  assign bus.scl_rise    = scl_rise_q;
  assign bus.scl_fall    = scl_fall_q;
  assign bus.start_pulse = start_q;
  assign bus.stop_pulse  = stop_q;
  assign bus.bus_busy    = busy_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: a window-based reference model queues the expected
// outputs each cycle; a negedge monitor pops and compares. Directed scenarios add checks.
module tb_i2c_bus_conditioner;
  localparam int L     = 4;
  localparam int T_CYC = 50;

  typedef logic [7:0] out_t;   // {scl_o, sda_o, rise, fall, start, stop, busy, timeout}

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  i2c_bus_conditioner_if bus ();

  i2c_bus_conditioner #(.FILTER_LEN(L), .TIMEOUT_CYCLES(T_CYC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
  endtask

  function automatic out_t dut_vec();
    return {bus.scl_o, bus.sda_o, bus.scl_rise, bus.scl_fall,
            bus.start_pulse, bus.stop_pulse, bus.bus_busy, bus.timeout};
  endfunction

  // Reference model: a filtered line flips when the last L synchronized samples
  // (raw input delayed by two clocks) all disagree with it.
  bit   pipe [2][$];
  bit   win  [2][$];
  bit   filt [2];
  bit   m_busy;
  int   m_low;
  out_t exp_q[$];

  always @(posedge clk) begin
    bit raw [2];
    bit nxt [2];
    bit s, flip, start, stop, tmo;
    raw[0] = bus.scl_i;
    raw[1] = bus.sda_i;
    if (!rstn) begin
      for (int l = 0; l < 2; l++) begin
        pipe[l] = {1'b1, 1'b1};
        win[l].delete();
        filt[l] = 1'b1;
      end
      m_busy = 1'b0;
      m_low  = 0;
      exp_q.push_back(8'b1100_0000);
    end else begin
      for (int l = 0; l < 2; l++) begin
        s = pipe[l].pop_front();
        pipe[l].push_back(raw[l]);
        win[l].push_back(s);
        if (win[l].size() > L) void'(win[l].pop_front());
        flip = (win[l].size() == L);
        foreach (win[l][i]) if (win[l][i] == filt[l]) flip = 1'b0;
        nxt[l] = flip ? !filt[l] : filt[l];
      end
      tmo = 1'b0;
`ifdef I2C_COND_TIMEOUT_EN
      if (m_busy && !filt[0]) begin
        m_low++;
        if (m_low == T_CYC) begin
          tmo   = 1'b1;
          m_low = 0;
        end
      end else begin
        m_low = 0;
      end
`endif
      start = filt[0] && nxt[0] && filt[1] && !nxt[1];
      stop  = filt[0] && nxt[0] && !filt[1] && nxt[1];
      if (start)            m_busy = 1'b1;
      else if (stop || tmo) m_busy = 1'b0;
      exp_q.push_back({nxt[0], nxt[1], nxt[0] & ~filt[0], ~nxt[0] & filt[0],
                       start, stop, m_busy, tmo});
      filt[0] = nxt[0];
      filt[1] = nxt[1];
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) check("outputs", dut_vec(), exp_q.pop_front());
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.scl_i = 1'b1;
    step($urandom_range(6, 10));
    bus.sda_i = 1'b0;
    step($urandom_range(6, 10));
  endtask

  task automatic do_stop();
    bus.scl_i = 1'b0;
    step($urandom_range(6, 10));
    bus.sda_i = 1'b0;
    step($urandom_range(6, 10));
    bus.scl_i = 1'b1;
    step($urandom_range(6, 10));
    bus.sda_i = 1'b1;
    step($urandom_range(6, 10));
  endtask

  task automatic glitch_sda();
    int len;
    len = $urandom_range(1, L - 1);
    bus.sda_i = ~bus.sda_i;
    step(len);
    bus.sda_i = ~bus.sda_i;
  endtask

  task automatic send_bit(input bit b);
    bus.scl_i = 1'b0;
    step($urandom_range(6, 10));
    bus.sda_i = b;
    step($urandom_range(6, 10));
    bus.scl_i = 1'b1;
    step($urandom_range(6, 10));
    if ($urandom_range(0, 3) == 0) glitch_sda();
    step($urandom_range(6, 10));
  endtask

  initial begin
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    rstn      = 1'b0;
    step(3);
    check("reset_values", dut_vec(), 8'b1100_0000);
    rstn = 1'b1;
    step(10);

    // Idle 3-cycle SCL low glitch must be swallowed.
    bus.scl_i = 1'b0;
    step(3);
    bus.scl_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_scl_o_fall_start", {5'b0, bus.scl_o, bus.scl_fall, bus.start_pulse}, 8'b100);
    end

    // START: sda_o falls and start_pulse fires exactly 2+L cycles after sda_i falls.
    bus.sda_i = 1'b0;
    step(5);
    check("start_before", {5'b0, bus.sda_o, bus.start_pulse, bus.bus_busy}, 8'b100);
    step(1);
    check("start_edge", {5'b0, bus.sda_o, bus.start_pulse, bus.bus_busy}, 8'b011);
    step(1);
    check("start_after", {5'b0, bus.sda_o, bus.start_pulse, bus.bus_busy}, 8'b001);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));

    // Repeated START keeps BUSY, then STOP clears busy in the pulse cycle.
    bus.scl_i = 1'b0; step(8);
    bus.sda_i = 1'b1; step(8);
    bus.scl_i = 1'b1; step(8);
    bus.sda_i = 1'b0; step(6);
    check("rstart_edge", {6'b0, bus.start_pulse, bus.bus_busy}, 8'b11);
    step(8);
    bus.scl_i = 1'b0; step(8);
    bus.sda_i = 1'b0; step(8);
    bus.scl_i = 1'b1; step(8);
    bus.sda_i = 1'b1; step(5);
    check("stop_before", {6'b0, bus.stop_pulse, bus.bus_busy}, 8'b01);
    step(1);
    check("stop_edge", {6'b0, bus.stop_pulse, bus.bus_busy}, 8'b10);
    step(8);

    // Simultaneous toggles: both edges together, no START/STOP.
    bus.scl_i = 1'b0; bus.sda_i = 1'b0; step(6);
    check("simul_fall", {3'b0, bus.scl_o, bus.sda_o, bus.scl_fall, bus.start_pulse, bus.stop_pulse},
          8'b00100);
    step(8);
    bus.scl_i = 1'b1; bus.sda_i = 1'b1; step(6);
    check("simul_rise", {3'b0, bus.scl_o, bus.sda_o, bus.scl_rise, bus.start_pulse, bus.stop_pulse},
          8'b11100);
    step(8);

    // SCL held low for 60 cycles while busy.
    do_start();
    bus.scl_i = 1'b0;
    step(6);
    check("to_scl_fell", {6'b0, bus.scl_o, bus.bus_busy}, 8'b01);
    step(T_CYC - 1);
    check("to_before", {6'b0, bus.timeout, bus.bus_busy}, 8'b01);
    step(1);
`ifdef I2C_COND_TIMEOUT_EN
    check("to_edge", {6'b0, bus.timeout, bus.bus_busy}, 8'b10);
    step(1);
    check("to_after", {6'b0, bus.timeout, bus.bus_busy}, 8'b00);
`else
    check("to_edge", {6'b0, bus.timeout, bus.bus_busy}, 8'b01);
    step(1);
    check("to_after", {6'b0, bus.timeout, bus.bus_busy}, 8'b01);
`endif
    step(3);
    bus.scl_i = 1'b1; step(8);
    bus.sda_i = 1'b1; step(8);
    check("to_released_idle", {7'b0, bus.bus_busy}, 8'b0);

    // Reset mid-byte: abort to IDLE with no STOP; low lines must re-qualify.
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    bus.scl_i = 1'b0;
    step(8);
    check("pre_reset", {6'b0, bus.scl_o, bus.bus_busy}, 8'b01);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    check("reset_mid_byte", dut_vec(), 8'b1100_0000);
    step(5);
    check("post_reset_hold", {6'b0, bus.scl_o, bus.sda_o}, 8'b11);
    step(1);
    check("post_reset_qualify",
          {3'b0, bus.scl_o, bus.sda_o, bus.start_pulse, bus.stop_pulse, bus.bus_busy}, 8'b0);
    step(4);
    bus.scl_i = 1'b1; step(8);
    bus.sda_i = 1'b1; step(8);

    // Randomized transfers with repeated STARTs and short SDA glitches.
    for (int t = 0; t < 8; t++) begin
      int nbits;
      nbits = $urandom_range(8, 18);
      do_start();
      for (int b = 0; b < nbits; b++) begin
        send_bit(1'($urandom));
        if (b == nbits / 2 && $urandom_range(0, 2) == 0) begin
          bus.scl_i = 1'b0; step($urandom_range(6, 10));
          bus.sda_i = 1'b1; step($urandom_range(6, 10));
          do_start();
        end
      end
      do_stop();
      if ($urandom_range(0, 1) == 1) begin
        bus.scl_i = 1'b0;
        step($urandom_range(1, L - 1));
        bus.scl_i = 1'b1;
      end
      step($urandom_range(5, 20));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
